i2c_reg_target: RTL and testbench

- I2C target (responder) for the register-write traffic the on-board config sequencer emits: [SLAVE_ADDR, SUB_ADDR, DATA...] byte streams.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, acknowledges its own 7-bit address, and manages an auto-incrementing register pointer.
- Each received data byte becomes a one-cycle write strobe; read transfers are served from an external register read port.
- Used as an on-FPGA codec/register model and as a loopback target for the config path.

---
 rtl/i2c_reg_target_if.sv | 39 +++
 rtl/i2c_reg_target.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_target_if.sv
// Bus-side signals of the I2C register target: the pad-level SCL/SDA
// pair, the register write strobe and the register read port.
interface i2c_reg_target_if;
    logic       iSCL;
    logic       iSDA;
    logic       oSDA_OE;
    logic       oWR_EN;
    logic [7:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic [7:0] oRD_ADDR;
    logic [7:0] iRD_DATA;
    logic       oBUSY;

    // The target block sees the bus and the register file from this side.
    modport slave (
        input  iSCL,
        input  iSDA,
        input  iRD_DATA,
        output oSDA_OE,
        output oWR_EN,
        output oWR_ADDR,
        output oWR_DATA,
        output oRD_ADDR,
        output oBUSY
    );

    // The environment (bus master plus register file) drives from this side.
    modport master (
        output iSCL,
        output iSDA,
        output iRD_DATA,
        input  oSDA_OE,
        input  oWR_EN,
        input  oWR_ADDR,
        input  oWR_DATA,
        input  oRD_ADDR,
        input  oBUSY
    );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register target: oversamples SCL/SDA on the system clock, acknowledges
// its own 7-bit address, keeps an auto-incrementing register pointer, turns
// every received data byte into a one-cycle write strobe and serves read
// transfers from an external register read port. It never stretches SCL.
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h10,
    parameter int         SYNC_STAGES = 2
) (
    input logic                iCLK,
    input logic                iRST_N,
    i2c_reg_target_if.slave    bus
);

    // Fewer than two metastability flops is never safe, so clamp the depth.
    localparam int SyncDepth = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_MACK
    } state_t;

    logic [SyncDepth-1:0] sclSync_q;
    logic [SyncDepth-1:0] sdaSync_q;
    logic                 sclHist_q;
    logic                 sdaHist_q;

    state_t     state_q;
    logic       sdaOe_q;
    logic       wrEn_q;
    logic [7:0] wrAddr_q;
    logic [7:0] wrData_q;
    logic       busy_q;
    logic [7:0] ptr_q;
    logic [7:0] shift_q;
    logic [2:0] bitCnt_q;
    logic       byteFull_q;
    logic       loadPend_q;
    logic       firstPend_q;

    logic       sclS;
    logic       sdaS;
    logic       sclRise;
    logic       sclFall;
    logic       startDet;
    logic       stopDet;
    logic [7:0] shiftIn_d;
    logic [2:0] bitCnt_d;
    logic [7:0] ptrInc_d;
    logic       addrMatch_d;

    // Synchronise the bus lines and keep one history sample for edge detection.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclHist_q <= 1'b1;
            sdaHist_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SyncDepth-2:0], bus.iSCL};
            sdaSync_q <= {sdaSync_q[SyncDepth-2:0], bus.iSDA};
            sclHist_q <= sclSync_q[SyncDepth-1];
            sdaHist_q <= sdaSync_q[SyncDepth-1];
        end
    end

    assign sclS     = sclSync_q[SyncDepth-1];
    assign sdaS     = sdaSync_q[SyncDepth-1];
    assign sclRise  = sclS & ~sclHist_q;
    assign sclFall  = ~sclS & sclHist_q;
    assign startDet = sclS & sclHist_q & sdaHist_q & ~sdaS;
    assign stopDet  = sclS & sclHist_q & ~sdaHist_q & sdaS;

    assign shiftIn_d   = {shift_q[6:0], sdaS};
    assign bitCnt_d    = bitCnt_q + 3'd1;
    assign ptrInc_d    = ptr_q + 8'd1;
    assign addrMatch_d = (shift_q[7:1] == DEV_ADDR);

    // Protocol state machine; every bus-visible output is a register set here.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            sdaOe_q     <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= 8'h00;
            wrData_q    <= 8'h00;
            busy_q      <= 1'b0;
            ptr_q       <= 8'h00;
            shift_q     <= 8'h00;
            bitCnt_q    <= 3'd0;
            byteFull_q  <= 1'b0;
            loadPend_q  <= 1'b0;
            firstPend_q <= 1'b0;
        end else begin
            wrEn_q <= 1'b0;

            // The pointer steps past a written register the cycle after its strobe.
            if (wrEn_q) begin
                ptr_q <= ptrInc_d;
            end

            if (startDet) begin
                state_q     <= ADDR;
                sdaOe_q     <= 1'b0;
                busy_q      <= 1'b0;
                bitCnt_q    <= 3'd0;
                byteFull_q  <= 1'b0;
                loadPend_q  <= 1'b0;
                firstPend_q <= 1'b0;
            end else if (stopDet) begin
                state_q     <= IDLE;
                sdaOe_q     <= 1'b0;
                busy_q      <= 1'b0;
                bitCnt_q    <= 3'd0;
                byteFull_q  <= 1'b0;
                loadPend_q  <= 1'b0;
                firstPend_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sdaOe_q <= 1'b0;
                    end

                    ADDR, SUB, WDATA: begin
                        if (sclRise && !byteFull_q) begin
                            shift_q  <= shiftIn_d;
                            bitCnt_q <= bitCnt_d;
                            if (bitCnt_q == 3'd7) begin
                                byteFull_q <= 1'b1;
                            end
                        end else if (sclFall && byteFull_q) begin
                            byteFull_q <= 1'b0;
                            bitCnt_q   <= 3'd0;
                            if (state_q == ADDR) begin
                                if (addrMatch_d) begin
                                    busy_q  <= 1'b1;
                                    sdaOe_q <= 1'b1;
                                    state_q <= ADDR_ACK;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else if (state_q == SUB) begin
                                ptr_q   <= shift_q;
                                sdaOe_q <= 1'b1;
                                state_q <= SUB_ACK;
                            end else begin
                                wrEn_q   <= 1'b1;
                                wrAddr_q <= ptr_q;
                                wrData_q <= shift_q;
                                sdaOe_q  <= 1'b1;
                                state_q  <= WDATA_ACK;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        // The ACK-ending fall of a read is also where bit 7 goes out.
                        if (sclFall) begin
                            bitCnt_q <= 3'd0;
                            if (shift_q[0]) begin
                                shift_q     <= bus.iRD_DATA;
                                sdaOe_q     <= ~bus.iRD_DATA[7];
                                firstPend_q <= 1'b0;
                                state_q     <= RDATA;
                            end else begin
                                sdaOe_q <= 1'b0;
                                state_q <= SUB;
                            end
                        end
                    end

                    SUB_ACK, WDATA_ACK: begin
                        if (sclFall) begin
                            sdaOe_q  <= 1'b0;
                            bitCnt_q <= 3'd0;
                            state_q  <= WDATA;
                        end
                    end

                    RDATA: begin
                        if (loadPend_q) begin
                            shift_q     <= bus.iRD_DATA;
                            loadPend_q  <= 1'b0;
                            firstPend_q <= 1'b1;
                        end else if (sclFall) begin
                            if (firstPend_q) begin
                                sdaOe_q     <= ~shift_q[7];
                                firstPend_q <= 1'b0;
                            end else if (bitCnt_q == 3'd7) begin
                                sdaOe_q <= 1'b0;
                                state_q <= RD_MACK;
                            end else begin
                                sdaOe_q  <= ~shift_q[6];
                                shift_q  <= {shift_q[6:0], 1'b0};
                                bitCnt_q <= bitCnt_d;
                            end
                        end
                    end

                    RD_MACK: begin
                        // The pointer moves past every byte handed out, ACKed or not.
                        if (sclRise) begin
                            ptr_q <= ptrInc_d;
                            if (!sdaS) begin
                                loadPend_q <= 1'b1;
                                bitCnt_q   <= 3'd0;
                                state_q    <= RDATA;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        sdaOe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oSDA_OE  = sdaOe_q;
    assign bus.oWR_EN   = wrEn_q;
    assign bus.oWR_ADDR = wrAddr_q;
    assign bus.oWR_DATA = wrData_q;
    assign bus.oRD_ADDR = ptr_q;
    assign bus.oBUSY    = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged bus master, a register file that
// answers reads with addr^0xA5, a table of single-write transfers, hand-built
// multi-cycle sequences and randomized transfers against a pointer model.
module tb_i2c_reg_target;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic rstN;
    logic sclM;
    logic sdaM;

    int testsRun    = 0;
    int testsFailed = 0;

    i2c_reg_target_if bus();

    assign bus.iSCL     = sclM;
    assign bus.iSDA     = sdaM & ~bus.oSDA_OE;
    assign bus.iRD_DATA = bus.oRD_ADDR ^ 8'hA5;

    i2c_reg_target #(.DEV_ADDR(7'h10), .SYNC_STAGES(2)) dut (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] devByte;
        logic [7:0] subByte;
        logic [7:0] dataByte;
        logic       expAck;
        int         expWrites;
        logic [7:0] expWrAddr;
        logic [7:0] expWrData;
    } vec_t;

    vec_t vecs[7];

    logic [15:0] wrLog[$];
    int          oeCycles  = 0;
    int          busyCycles = 0;
    int          wrDouble  = 0;
    logic        wrPrev    = 1'b0;
    logic [7:0]  refPtr;

    // Record every write strobe and count cycles SDA is pulled or BUSY is high.
    always @(negedge clk) begin
        if (bus.oWR_EN) wrLog.push_back({bus.oWR_ADDR, bus.oWR_DATA});
        if (bus.oWR_EN && wrPrev) wrDouble <= wrDouble + 1;
        wrPrev <= bus.oWR_EN;
        if (bus.oSDA_OE) oeCycles <= oeCycles + 1;
        if (bus.oBUSY) busyCycles <= busyCycles + 1;
    end

    // Hard time limit so a stuck bench still stops.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; quarter();
        sclM = 1'b1; quarter();
        sdaM = 1'b0; quarter();
        sclM = 1'b0; quarter();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; quarter();
        sclM = 1'b1; quarter();
        sdaM = 1'b1; quarter();
        quarter();
    endtask

    task automatic writeBit(input logic b);
        sdaM = b; quarter();
        sclM = 1'b1; quarter(); quarter();
        sclM = 1'b0; quarter();
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1; quarter();
        sclM = 1'b1; quarter();
        #1 b = bus.iSDA;
        quarter();
        sclM = 1'b0; quarter();
    endtask

    task automatic writeByte(input logic [7:0] v, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) writeBit(v[i]);
        readBit(b);
        acked = ~b;
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            v[i] = b;
        end
        writeBit(~masterAck);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic acked;
        int   wrBase;
        int   oeBase;
        int   busyBase;
        wrBase   = wrLog.size();
        oeBase   = oeCycles;
        busyBase = busyCycles;
        i2cStart();
        writeByte(v.devByte, acked);
        checkOutput($sformatf("vec%0d addrAck", idx), 32'(acked), 32'(v.expAck));
        @(negedge clk);
        checkOutput($sformatf("vec%0d busyAfterAddr", idx), 32'(bus.oBUSY), 32'(v.expAck));
        writeByte(v.subByte, acked);
        checkOutput($sformatf("vec%0d subAck", idx), 32'(acked), 32'(v.expAck));
        writeByte(v.dataByte, acked);
        checkOutput($sformatf("vec%0d dataAck", idx), 32'(acked), 32'(v.expAck));
        i2cStop();
        @(negedge clk);
        checkOutput($sformatf("vec%0d wrCount", idx), 32'(wrLog.size() - wrBase), 32'(v.expWrites));
        if (v.expWrites > 0 && wrLog.size() > wrBase)
            checkOutput($sformatf("vec%0d wrAddrData", idx), 32'(wrLog[wrBase]), 32'({v.expWrAddr, v.expWrData}));
        if (!v.expAck) begin
            checkOutput($sformatf("vec%0d oeQuiet", idx), 32'(oeCycles - oeBase), 32'd0);
            checkOutput($sformatf("vec%0d busyQuiet", idx), 32'(busyCycles - busyBase), 32'd0);
        end
        if (v.expAck) refPtr = v.subByte + 8'd1;
        checkOutput($sformatf("vec%0d busyAfterStop", idx), 32'(bus.oBUSY), 32'd0);
        checkOutput($sformatf("vec%0d pointer", idx), 32'(bus.oRD_ADDR), 32'(refPtr));
    endtask

    initial begin
        logic       acked;
        logic [7:0] rd;
        int         wrBase;
        int         n;
        logic [7:0] dev;
        logic [7:0] sub;
        logic [7:0] dat;
        logic       match;
        logic [15:0] expQ[$];

        vecs[0] = '{8'h20, 8'h02, 8'h27, 1'b1, 1, 8'h02, 8'h27};
        vecs[1] = '{8'hC0, 8'h02, 8'h53, 1'b0, 0, 8'h00, 8'h00};
        vecs[2] = '{8'h20, 8'h7F, 8'hA5, 1'b1, 1, 8'h7F, 8'hA5};
        vecs[3] = '{8'h22, 8'h10, 8'h10, 1'b0, 0, 8'h00, 8'h00};
        vecs[4] = '{8'h00, 8'h33, 8'h44, 1'b0, 0, 8'h00, 8'h00};
        vecs[5] = '{8'hA0, 8'h01, 8'h02, 1'b0, 0, 8'h00, 8'h00};
        vecs[6] = '{8'h20, 8'hFF, 8'h00, 1'b1, 1, 8'hFF, 8'h00};

        sclM = 1'b1;
        sdaM = 1'b1;
        rstN = 1'b0;
        refPtr = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("reset sdaOe", 32'(bus.oSDA_OE), 32'd0);
        checkOutput("reset wrEn", 32'(bus.oWR_EN), 32'd0);
        checkOutput("reset wrAddrData", 32'({bus.oWR_ADDR, bus.oWR_DATA}), 32'd0);
        checkOutput("reset busy", 32'(bus.oBUSY), 32'd0);
        checkOutput("reset pointer", 32'(bus.oRD_ADDR), 32'd0);
        rstN = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        // Burst write wrapping the pointer through 0xFF.
        wrBase = wrLog.size();
        i2cStart();
        writeByte(8'h20, acked); checkOutput("burst addrAck", 32'(acked), 32'd1);
        writeByte(8'hFE, acked); checkOutput("burst subAck", 32'(acked), 32'd1);
        writeByte(8'h11, acked); checkOutput("burst d0Ack", 32'(acked), 32'd1);
        writeByte(8'h22, acked); checkOutput("burst d1Ack", 32'(acked), 32'd1);
        writeByte(8'h33, acked); checkOutput("burst d2Ack", 32'(acked), 32'd1);
        i2cStop();
        @(negedge clk);
        checkOutput("burst wrCount", 32'(wrLog.size() - wrBase), 32'd3);
        if (wrLog.size() >= wrBase + 3) begin
            checkOutput("burst wr0", 32'(wrLog[wrBase]), 32'h FE11);
            checkOutput("burst wr1", 32'(wrLog[wrBase+1]), 32'h FF22);
            checkOutput("burst wr2", 32'(wrLog[wrBase+2]), 32'h 0033);
        end
        refPtr = 8'h01;
        checkOutput("burst pointer", 32'(bus.oRD_ADDR), 32'h01);

        // Set pointer, repeated START, read two bytes.
        i2cStart();
        writeByte(8'h20, acked); checkOutput("read wAddrAck", 32'(acked), 32'd1);
        writeByte(8'h10, acked); checkOutput("read subAck", 32'(acked), 32'd1);
        i2cStart();
        writeByte(8'h21, acked); checkOutput("read rAddrAck", 32'(acked), 32'd1);
        readByte(1'b1, rd); checkOutput("read byte0", 32'(rd), 32'hB5);
        readByte(1'b0, rd); checkOutput("read byte1", 32'(rd), 32'hB4);
        @(negedge clk);
        checkOutput("read sdaReleased", 32'(bus.oSDA_OE), 32'd0);
        i2cStop();
        @(negedge clk);
        checkOutput("read pointer", 32'(bus.oRD_ADDR), 32'h12);
        checkOutput("read busyAfterStop", 32'(bus.oBUSY), 32'd0);
        refPtr = 8'h12;

        // STOP in the middle of a data byte.
        wrBase = wrLog.size();
        i2cStart();
        writeByte(8'h20, acked);
        writeByte(8'h40, acked);
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
        i2cStop();
        @(negedge clk);
        checkOutput("partial wrCount", 32'(wrLog.size() - wrBase), 32'd0);
        checkOutput("partial busy", 32'(bus.oBUSY), 32'd0);
        i2cStart();
        writeByte(8'h20, acked); checkOutput("partial nextAck", 32'(acked), 32'd1);
        i2cStop();
        @(negedge clk);
        checkOutput("partial pointer", 32'(bus.oRD_ADDR), 32'h40);
        refPtr = 8'h40;

        // Reset while the target holds SDA low for an ACK.
        i2cStart();
        for (int i = 7; i >= 0; i--) writeBit(i == 5);
        sdaM = 1'b1;
        quarter();
        @(negedge clk);
        checkOutput("rstAck oeBefore", 32'(bus.oSDA_OE), 32'd1);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstAck oe", 32'(bus.oSDA_OE), 32'd0);
        checkOutput("rstAck busy", 32'(bus.oBUSY), 32'd0);
        checkOutput("rstAck pointer", 32'(bus.oRD_ADDR), 32'd0);
        rstN = 1'b1;
        quarter();
        sclM = 1'b1;
        quarter();
        refPtr = 8'h00;

        // Randomized transfers checked against the pointer model.
        for (int t = 0; t < 16; t++) begin
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 2) != 2) begin
                dev = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h20;
                dev[0] = 1'b0;
                match = (dev[7:1] == 7'h10);
                sub = 8'($urandom_range(0, 255));
                expQ.delete();
                wrBase = wrLog.size();
                i2cStart();
                writeByte(dev, acked);
                checkOutput($sformatf("rnd%0d wAddrAck", t), 32'(acked), 32'(match));
                writeByte(sub, acked);
                checkOutput($sformatf("rnd%0d subAck", t), 32'(acked), 32'(match));
                if (match) refPtr = sub;
                for (int k = 0; k < n; k++) begin
                    dat = 8'($urandom_range(0, 255));
                    writeByte(dat, acked);
                    checkOutput($sformatf("rnd%0d dataAck%0d", t, k), 32'(acked), 32'(match));
                    if (match) begin
                        expQ.push_back({refPtr, dat});
                        refPtr = refPtr + 8'd1;
                    end
                end
                i2cStop();
                @(negedge clk);
                checkOutput($sformatf("rnd%0d wrCount", t), 32'(wrLog.size() - wrBase), 32'(expQ.size()));
                for (int k = 0; k < expQ.size(); k++)
                    if (wrBase + k < wrLog.size())
                        checkOutput($sformatf("rnd%0d wr%0d", t, k), 32'(wrLog[wrBase+k]), 32'(expQ[k]));
            end else begin
                i2cStart();
                writeByte(8'h21, acked);
                checkOutput($sformatf("rnd%0d rAddrAck", t), 32'(acked), 32'd1);
                for (int k = 0; k < n; k++) begin
                    readByte(k != n - 1, rd);
                    checkOutput($sformatf("rnd%0d rd%0d", t, k), 32'(rd), 32'(refPtr ^ 8'hA5));
                    refPtr = refPtr + 8'd1;
                end
                i2cStop();
                @(negedge clk);
            end
            checkOutput($sformatf("rnd%0d pointer", t), 32'(bus.oRD_ADDR), 32'(refPtr));
            checkOutput($sformatf("rnd%0d busyAfterStop", t), 32'(bus.oBUSY), 32'd0);
        end

        checkOutput("wrEn singlePulse", 32'(wrDouble), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
